// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Also runs a memory-wait watchdog and saturating performance counters.
module pipeline_hazard_controller #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             hazard,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             stall_pipe,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] hazard_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    HAZ      = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam int WL = $clog2(MAX_WAIT + 1);
  localparam int WW = (WL > 7) ? WL : 7;
  localparam logic [WW-1:0]    W_MAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0]    W_ONE = WW'(1);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t        st;
  state_t        st_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          hit_exe;
  logic          hit_mem;
  logic          raw;

  always_comb begin
    hit_exe = (src1 == exe_dest) | (two_src & (src2 == exe_dest));
    hit_mem = (src1 == mem_dest) | (two_src & (src2 == mem_dest));
    if (forward_en)
      raw = id_valid & exe_wb_en & exe_mem_r_en & hit_exe;
    else
      raw = id_valid & ((exe_wb_en & hit_exe) | (mem_wb_en & hit_mem));
  end

  // A busy memory freezes EXE, so a coincident branch is simply replayed.
  always_comb begin
    hazard       = 1'b0;
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    stall_pipe   = 1'b0;
    st_nxt       = RUN;
    if (rst) begin
      st_nxt = RUN;
    end else if (mem_busy) begin
      stall_pipe   = 1'b1;
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      st_nxt       = MEM_WAIT;
    end else if (branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_exe = 1'b1;
    end else if (raw) begin
      hazard       = 1'b1;
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      st_nxt       = HAZ;
    end
  end

  always_comb begin
    if (st_nxt != MEM_WAIT)
      wait_nxt = '0;
    else if (st != MEM_WAIT)
      wait_nxt = W_ONE;
    else if (wait_cnt < W_MAX)
      wait_nxt = wait_cnt + W_ONE;
    else
      wait_nxt = wait_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= RUN;
      wait_cnt       <= '0;
      mem_timeout    <= 1'b0;
      hazard_count   <= '0;
      flush_count    <= '0;
      mem_wait_count <= '0;
    end else begin
      st       <= st_nxt;
      wait_cnt <= wait_nxt;
      if (mem_busy && (wait_nxt == W_MAX))
        mem_timeout <= 1'b1;
      if (hazard && (hazard_count != C_MAX))
        hazard_count <= hazard_count + C_ONE;
      if (flush_if_id && (flush_count != C_MAX))
        flush_count <= flush_count + C_ONE;
      if (stall_pipe && (mem_wait_count != C_MAX))
        mem_wait_count <= mem_wait_count + C_ONE;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller.
// Control vectors are queued at drive time and popped when sampled.
module tb_pipeline_hazard_controller;

  localparam int CW = 16;

  // {hazard, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, stall_pipe}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_HAZ   = 6'b111000;
  localparam logic [5:0] C_FLUSH = 6'b000110;
  localparam logic [5:0] C_STALL = 6'b011001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [3:0]    src1 = '0;
  logic [3:0]    src2 = '0;
  logic          two_src = 1'b0;
  logic [3:0]    exe_dest = '0;
  logic          exe_wb_en = 1'b0;
  logic          exe_mem_r_en = 1'b0;
  logic [3:0]    mem_dest = '0;
  logic          mem_wb_en = 1'b0;
  logic          forward_en = 1'b0;
  logic          branch_taken = 1'b0;
  logic          mem_busy = 1'b0;
  logic          hazard;
  logic          freeze_pc;
  logic          freeze_if_id;
  logic          flush_if_id;
  logic          flush_id_exe;
  logic          stall_pipe;
  logic [1:0]    state;
  logic          mem_timeout;
  logic [CW-1:0] hazard_count;
  logic [CW-1:0] flush_count;
  logic [CW-1:0] mem_wait_count;
  logic [5:0]    ctl;

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  pipeline_hazard_controller #(.MAX_WAIT(64), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .forward_en(forward_en),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .hazard(hazard), .freeze_pc(freeze_pc),
    .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .stall_pipe(stall_pipe),
    .state(state), .mem_timeout(mem_timeout),
    .hazard_count(hazard_count), .flush_count(flush_count),
    .mem_wait_count(mem_wait_count)
  );

  always #5 clk = ~clk;

  assign ctl = {hazard, freeze_pc, freeze_if_id,
                flush_if_id, flush_id_exe, stall_pipe};

  task automatic clr();
    id_valid = 0; src1 = 0; src2 = 0; two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; forward_en = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic sched(input logic [5:0] e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk); clr(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    @(negedge clk); clr(); rst = 1;
    mem_busy = 1; branch_taken = 1; id_valid = 1; exe_wb_en = 1;
    sched(C_NONE);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({state, mem_timeout, hazard_count, flush_count,
         mem_wait_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_regs got st=%b to=%b hc=%0d fc=%0d mc=%0d exp=0",
               state, mem_timeout, hazard_count, flush_count, mem_wait_count);
    end
    @(negedge clk); rst = 0; clr();
  endtask

  task automatic test_raw_no_fwd();
    logic [5:0] e;
    @(negedge clk); clr();
    id_valid = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1;
    sched(C_HAZ);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL raw_exe got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, hazard_count} !== {2'b01, 16'd1}) begin
      n_bad++;
      $display("FAIL raw_exe_state got st=%b hc=%0d exp st=01 hc=1",
               state, hazard_count);
    end
    @(negedge clk); id_valid = 0;
    sched(C_NONE);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL bubble got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, hazard_count} !== {2'b00, 16'd1}) begin
      n_bad++;
      $display("FAIL bubble_state got st=%b hc=%0d exp st=00 hc=1",
               state, hazard_count);
    end
    @(negedge clk); clr();
    id_valid = 1; src1 = 0; exe_dest = 4; exe_wb_en = 1;
    mem_dest = 0; mem_wb_en = 1;
    sched(C_HAZ);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL r0_mem got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if (hazard_count !== 16'd2) begin
      n_bad++; $display("FAIL r0_mem_cnt got=%0d exp=2", hazard_count);
    end
  endtask

  task automatic test_forward();
    logic [5:0] e;
    @(negedge clk); clr();
    forward_en = 1; id_valid = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1;
    sched(C_NONE);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL fwd_alu got=%b exp=%b", ctl, e);
    end
    @(negedge clk); exe_mem_r_en = 1;
    sched(C_HAZ);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL load_use got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, hazard_count} !== {2'b01, 16'd3}) begin
      n_bad++;
      $display("FAIL load_use_state got st=%b hc=%0d exp st=01 hc=3",
               state, hazard_count);
    end
    @(negedge clk);
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 3; mem_wb_en = 1;
    sched(C_NONE);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL load_in_mem got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, hazard_count} !== {2'b00, 16'd3}) begin
      n_bad++;
      $display("FAIL load_in_mem_state got st=%b hc=%0d exp st=00 hc=3",
               state, hazard_count);
    end
  endtask

  task automatic test_two_src();
    logic [5:0] e;
    @(negedge clk); clr();
    id_valid = 1; src1 = 1; src2 = 5; mem_dest = 5; mem_wb_en = 1;
    sched(C_NONE);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL src2_unused got=%b exp=%b", ctl, e);
    end
    @(negedge clk); two_src = 1;
    sched(C_HAZ);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL src2_used got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if (hazard_count !== 16'd4) begin
      n_bad++; $display("FAIL src2_cnt got=%0d exp=4", hazard_count);
    end
  endtask

  task automatic test_branch();
    logic [5:0] e;
    @(negedge clk); clr();
    id_valid = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1; branch_taken = 1;
    sched(C_FLUSH);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL branch_over_raw got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, flush_count, hazard_count} !== {2'b00, 16'd1, 16'd4}) begin
      n_bad++;
      $display("FAIL branch_cnt got st=%b fc=%0d hc=%0d exp st=00 fc=1 hc=4",
               state, flush_count, hazard_count);
    end
    @(negedge clk); mem_busy = 1;
    sched(C_STALL);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL busy_over_branch got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, flush_count, mem_wait_count} !== {2'b10, 16'd1, 16'd1}) begin
      n_bad++;
      $display("FAIL busy_branch_cnt got st=%b fc=%0d mc=%0d exp st=10 fc=1 mc=1",
               state, flush_count, mem_wait_count);
    end
    @(negedge clk); mem_busy = 0;
    sched(C_FLUSH);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL branch_replay got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, flush_count} !== {2'b00, 16'd2}) begin
      n_bad++;
      $display("FAIL branch_replay_cnt got st=%b fc=%0d exp st=00 fc=2",
               state, flush_count);
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] e;
    logic       ex_to;
    int         bad_k;
    rst_pulse();
    bad_k = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk); clr(); mem_busy = 1;
      sched(C_STALL);
      e = exp_q.pop_front(); n_cmp++;
      if (ctl !== e) begin
        n_bad++; $display("FAIL wait_ctl k=%0d got=%b exp=%b", k, ctl, e);
      end
      @(posedge clk); #1;
      ex_to = (k >= 64);
      n_cmp++;
      if ({state, mem_timeout, mem_wait_count} !== {2'b10, ex_to, 16'(k)}) begin
        n_bad++;
        $display("FAIL wait_k%0d got st=%b to=%b mc=%0d exp st=10 to=%b mc=%0d",
                 k, state, mem_timeout, mem_wait_count, ex_to, k);
      end
    end
    @(negedge clk); rst = 1; mem_busy = 1;
    sched(C_NONE);
    e = exp_q.pop_front(); n_cmp++;
    if (ctl !== e) begin
      n_bad++; $display("FAIL rst_in_wait_ctl got=%b exp=%b", ctl, e);
    end
    @(posedge clk); #1; n_cmp++;
    if ({state, mem_timeout, mem_wait_count} !== '0) begin
      n_bad++;
      $display("FAIL rst_in_wait got st=%b to=%b mc=%0d exp all 0",
               state, mem_timeout, mem_wait_count);
    end
    @(negedge clk); rst = 0; clr();
    // Interrupted wait must restart the watchdog from 1.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); mem_busy = 1;
    end
    @(negedge clk); mem_busy = 0;
    for (int k = 0; k < 63; k++) begin
      @(negedge clk); mem_busy = 1;
      @(posedge clk); #1;
      if (mem_timeout !== 1'b0 && bad_k == 0) bad_k = k + 1;
    end
    n_cmp++;
    if (bad_k != 0 || mem_wait_count !== 16'd103) begin
      n_bad++;
      $display("FAIL wait_restart got early_to_at=%0d mc=%0d exp 0 and 103",
               bad_k, mem_wait_count);
    end
    @(negedge clk); mem_busy = 1;
    @(posedge clk); #1; n_cmp++;
    if ({mem_timeout, mem_wait_count} !== {1'b1, 16'd104}) begin
      n_bad++;
      $display("FAIL wait_restart_to got to=%b mc=%0d exp to=1 mc=104",
               mem_timeout, mem_wait_count);
    end
    @(negedge clk); clr();
    @(posedge clk); #1; n_cmp++;
    if ({state, mem_timeout} !== {2'b00, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_sticky got st=%b to=%b exp st=00 to=1",
               state, mem_timeout);
    end
  endtask

  task automatic test_saturation();
    rst_pulse();
    @(negedge clk); clr();
    id_valid = 1; src1 = 3; exe_dest = 3; exe_wb_en = 1;
    repeat (65540) @(posedge clk);
    #1; n_cmp++;
    if ({state, hazard_count, flush_count} !== {2'b01, 16'hFFFF, 16'd0}) begin
      n_bad++;
      $display("FAIL hazard_sat got st=%b hc=%h fc=%0d exp st=01 hc=ffff fc=0",
               state, hazard_count, flush_count);
    end
  endtask

  initial begin
    clr();
    rst = 1;
    test_reset();
    test_raw_no_fwd();
    test_forward();
    test_two_src();
    test_branch();
    test_mem_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
